bpc_stream_framer: RTL and testbench
====================================

// Module: bpc_stream_framer
// PURPOSE
// - Upstream feeder of the BPC decompressor.
// - Takes the raw compressed stream from the memory read path: 64-bit words, no framing.
//   Each block starts with one header word, followed by LEN payload words.
// - Strips the header and forwards the payload with sop/eop marks on a valid/ready interface.
// - Checks each header and drops bad ones. Reports errors and block ids to status logic.
// PARAMETERS
// - DATA_W     64  stream word width; header field positions below assume 64
// - LEN_W      5   width of the header length field
// - MAX_WORDS  17  largest legal payload length, in words (worst-case BPC block)
// - SYNC       8'hBC  header sync byte, header[63:56]
// PORTS
// - clk        in   1       clock
// - rst_n      in   1       asynchronous, active-low reset
// - s_valid    in   1       input word valid
// - s_data     in   DATA_W  input word (header or payload)
// - s_ready    out  1       input accepted when s_valid & s_ready
// - m_valid    out  1       output payload beat valid
// - m_data     out  DATA_W  payload word
// - m_sop      out  1       first payload word of a block
// - m_eop      out  1       last payload word of a block
// - m_ready    in   1       decompressor ready; beat moves on m_valid & m_ready
// - blk_id     out  16      header[55:40] of the block now in progress; held until the next good header
// - err_pulse  out  1       one-cycle strobe when a header is dropped
// - err_code   out  2       1 = sync mismatch; 2 = length illegal; held until the next error
// - blk_cnt    out  16      count of completed blocks (eop beats accepted on input side); wraps
// BEHAVIOUR
// - Reset values:
//   - s_ready = 0 during reset, 1 in the first cycle after.
//   - All m_* outputs = 0.
//   - blk_id, err_pulse, err_code, blk_cnt = 0.
//   - FSM = HDR; skid buffer empty.
// - Header format:
//   - [63:56] sync, [55:40] block id, [LEN_W-1:0] LEN.
//   - All other bits are ignored.
// - FSM (advances only on an input handshake):
//   - HDR, good header (sync == SYNC and 1 <= LEN <= MAX_WORDS):
//     - latch LEN into rem_cnt and the id into blk_id;
//     - set first_flag; go to PAY.
//     - The header word is never forwarded.
//   - HDR, bad header:
//     - drop the word; assert err_pulse for one cycle; set err_code;
//     - stay in HDR. The next word is treated as a header, so the block re-synchronises word by word.
//     - When both checks fail, err_code = 1.
//   - PAY, each accepted word:
//     - push {word, sop = first_flag, eop = (rem_cnt == 1)} into the skid buffer;
//     - clear first_flag; decrement rem_cnt.
//     - If rem_cnt == 1: increment blk_cnt and go to HDR.
//   - LEN == 1: a single beat with sop = eop = 1.
// - Output skid buffer (2 entries, registered outputs):
//   - s_ready = buffer not full. It is a registered signal with no combinational path from m_ready.
//   - Latency from payload acceptance to m_valid = 1 cycle, with no stall.
//   - Throughput is 1 word/cycle while m_ready stays high.
//   - m_data, m_sop and m_eop stay stable while m_valid & !m_ready. No beat is lost or duplicated.
//   - A simultaneous push and pop with one entry held keeps the occupancy at 1.
//   - Full and no pop: s_ready = 0 next cycle.
// - While in HDR, s_ready still follows buffer space, so header parsing never overtakes beats already queued.
// - The stream is back-to-back: the next header may be accepted in the cycle after the previous eop word.
// - Reset mid-block:
//   - queued beats are discarded; FSM returns to HDR;
//   - the first word after reset is parsed as a header.
//   - The downstream decompressor is reset by the same rst_n.
// - Counters:
//   - rem_cnt is LEN_W bits wide and never underflows (PAY is left at rem_cnt == 1).
//   - blk_cnt wraps from 16'hFFFF to 0.
// STRUCTURE
// - Shared package bpc_pkg:
//   - BPC_SYNC, BPC_MAX_WORDS, the header field bit positions;
//   - the err_code encodings (ERR_SYNC = 2'd1, ERR_LEN = 2'd2);
//   - the FSM state typedef {HDR, PAY}.
// - One sub-module: bpc_skid_buf (parameter W, 2 entries, valid/ready on both sides).
//   - It carries {sop, eop, data}.
//   - It is reusable on the decompressor output.
// TESTING
// - Header(id=0x1234, LEN=3) then words A, B, C, m_ready = 1:
//   - 3 beats, A with sop, C with eop, first beat 1 cycle after A is accepted;
//   - blk_id = 0x1234; blk_cnt = 1.
// - Header(LEN=1) then D:
//   - one beat D with m_sop = m_eop = 1.
//   - Then a header(LEN=17) and 17 words back-to-back: 17 beats with no bubble at 1 word/cycle.
// - Header(LEN=4), 4 words, m_ready toggling 1010...:
//   - output sequence identical, with no drop or duplicate;
//   - data held stable while stalled;
//   - s_ready = 0 exactly while 2 beats are buffered.
// - Word 0xAA00_..._0003 in HDR:
//   - err_pulse = 1 for one cycle, err_code = 1, no m_valid.
//   - A following good header(LEN=2) is framed correctly.
// - Headers with LEN = 0 and LEN = 18:
//   - each gives err_code = 2, one err_pulse each, both words dropped.
// - rst_n low for 1 cycle after word 2 of a LEN=5 block:
//   - m_valid = 0, blk_cnt = 0, s_ready = 1 one cycle after release;
//   - the next word is parsed as a header.

Source files
------------

// File: rtl/bpc_pkg.sv
// Shared BPC definitions: sync byte, block size limit, header field positions,
// error encodings and the framer state type.
package bpc_pkg;

    localparam logic [7:0] BPC_SYNC      = 8'hBC;
    localparam int         BPC_MAX_WORDS = 17;

    localparam int HDR_SYNC_LSB = 56;
    localparam int HDR_ID_LSB   = 40;
    localparam int HDR_ID_W     = 16;

    localparam logic [1:0] ERR_SYNC = 2'd1;
    localparam logic [1:0] ERR_LEN  = 2'd2;

    typedef enum logic {
        HDR = 1'b0,
        PAY = 1'b1
    } bpc_state_e;

endpackage

// File: rtl/bpc_stream_framer_if.sv
// Stream bundle of the framer: raw word input side and framed payload output side.
interface bpc_stream_framer_if #(
    parameter int DATA_W = 64
);
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_sop;
    logic              m_eop;
    logic              m_ready;

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_sop, m_eop
    );

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_sop, m_eop
    );
endinterface

// File: rtl/bpc_skid_buf.sv
// Two-entry skid buffer with registered outputs and a registered in_ready,
// so there is no combinational path from out_ready back to in_ready.
module bpc_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready
);
    logic [1:0]   cnt_q, cnt_d;
    logic         rdy_q, rdy_d;
    logic [W-1:0] ent0_q, ent0_d;
    logic [W-1:0] ent1_q, ent1_d;
    logic         push, pop;

    assign push      = in_valid & rdy_q;
    assign pop       = (cnt_q != 2'd0) & out_ready;
    assign in_ready  = rdy_q;
    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = ent0_q;

    // ent0 is always the head (output register); ent1 only fills when the head stalls
    always_comb begin
        cnt_d  = cnt_q;
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        case (cnt_q)
            2'd0: begin
                if (push) begin
                    ent0_d = in_data;
                    cnt_d  = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    ent0_d = in_data;
                end else if (push) begin
                    ent1_d = in_data;
                    cnt_d  = 2'd2;
                end else if (pop) begin
                    cnt_d  = 2'd0;
                end
            end
            default: begin
                if (pop) begin
                    ent0_d = ent1_q;
                    cnt_d  = 2'd1;
                end
            end
        endcase
        rdy_d = (cnt_d != 2'd2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= 2'd0;
            rdy_q  <= 1'b0;
            ent0_q <= '0;
            ent1_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            rdy_q  <= rdy_d;
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
        end
    end

endmodule

// File: rtl/bpc_stream_framer.sv
// Strips BPC block headers from the raw compressed stream, validates them and
// forwards the payload words with sop/eop marks through a skid buffer.
module bpc_stream_framer
    import bpc_pkg::*;
#(
    parameter int         DATA_W    = 64,
    parameter int         LEN_W     = 5,
    parameter int         MAX_WORDS = BPC_MAX_WORDS,
    parameter logic [7:0] SYNC      = BPC_SYNC
) (
    input  logic                clk,
    input  logic                rst_n,
    bpc_stream_framer_if.slave  bus,
    output logic [HDR_ID_W-1:0] blk_id,
    output logic                err_pulse,
    output logic [1:0]          err_code,
    output logic [15:0]         blk_cnt
);
    bpc_state_e          state_q, state_d;
    logic [LEN_W-1:0]    rem_cnt_q, rem_cnt_d;
    logic                first_q, first_d;
    logic [HDR_ID_W-1:0] blk_id_q, blk_id_d;
    logic [15:0]         blk_cnt_q, blk_cnt_d;
    logic                err_pulse_q, err_pulse_d;
    logic [1:0]          err_code_q, err_code_d;

    logic             in_hs, hdr_sync_ok, hdr_len_ok, hdr_good, last_word;
    logic [LEN_W-1:0] hdr_len;
    logic             push_valid, push_sop, push_eop, hdr_err;
    logic [DATA_W+1:0] skid_out;

    assign in_hs       = bus.s_valid & bus.s_ready;
    assign hdr_len     = bus.s_data[LEN_W-1:0];
    assign hdr_sync_ok = (bus.s_data[HDR_SYNC_LSB +: 8] == SYNC);
    assign hdr_len_ok  = (hdr_len != '0) && (32'(hdr_len) <= 32'(MAX_WORDS));
    assign hdr_good    = hdr_sync_ok & hdr_len_ok;
    assign last_word   = (rem_cnt_q == LEN_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= HDR;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            HDR:     if (in_hs && hdr_good) state_d = PAY;
            PAY:     if (in_hs && last_word) state_d = HDR;
            default: state_d = HDR;
        endcase
    end

    always_comb begin
        push_valid = 1'b0;
        push_sop   = 1'b0;
        push_eop   = 1'b0;
        hdr_err    = 1'b0;
        case (state_q)
            HDR: hdr_err = in_hs & ~hdr_good;
            PAY: begin
                push_valid = bus.s_valid;
                push_sop   = first_q;
                push_eop   = last_word;
            end
            default: ;
        endcase
    end

    // A word failing both checks reports the sync error
    always_comb begin
        rem_cnt_d   = rem_cnt_q;
        first_d     = first_q;
        blk_id_d    = blk_id_q;
        blk_cnt_d   = blk_cnt_q;
        err_pulse_d = hdr_err;
        err_code_d  = err_code_q;
        if (hdr_err) err_code_d = hdr_sync_ok ? ERR_LEN : ERR_SYNC;
        if (in_hs && state_q == HDR && hdr_good) begin
            rem_cnt_d = hdr_len;
            first_d   = 1'b1;
            blk_id_d  = bus.s_data[HDR_ID_LSB +: HDR_ID_W];
        end
        if (in_hs && state_q == PAY) begin
            first_d   = 1'b0;
            rem_cnt_d = rem_cnt_q - LEN_W'(1);
            if (last_word) blk_cnt_d = blk_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_cnt_q   <= '0;
            first_q     <= 1'b0;
            blk_id_q    <= '0;
            blk_cnt_q   <= '0;
            err_pulse_q <= 1'b0;
            err_code_q  <= 2'd0;
        end else begin
            rem_cnt_q   <= rem_cnt_d;
            first_q     <= first_d;
            blk_id_q    <= blk_id_d;
            blk_cnt_q   <= blk_cnt_d;
            err_pulse_q <= err_pulse_d;
            err_code_q  <= err_code_d;
        end
    end

    assign blk_id    = blk_id_q;
    assign blk_cnt   = blk_cnt_q;
    assign err_pulse = err_pulse_q;
    assign err_code  = err_code_q;

    bpc_skid_buf #(
        .W(DATA_W + 2)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (push_valid),
        .in_data  ({push_sop, push_eop, bus.s_data}),
        .in_ready (bus.s_ready),
        .out_valid(bus.m_valid),
        .out_data (skid_out),
        .out_ready(bus.m_ready)
    );

    assign bus.m_sop  = skid_out[DATA_W+1];
    assign bus.m_eop  = skid_out[DATA_W];
    assign bus.m_data = skid_out[DATA_W-1:0];

endmodule

// File: tb/tb_bpc_stream_framer.sv
// Testbench for bpc_stream_framer: scenario tasks against a block-level expected-beat model.
module tb_bpc_stream_framer;
    import bpc_pkg::*;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] blk_id, blk_cnt;
    logic        err_pulse;
    logic [1:0]  err_code;

    bpc_stream_framer_if #(.DATA_W(64)) bus ();

    bpc_stream_framer #(
        .DATA_W(64), .LEN_W(5), .MAX_WORDS(17), .SYNC(8'hBC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .blk_id(blk_id), .err_pulse(err_pulse), .err_code(err_code), .blk_cnt(blk_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] data;
        logic        sop;
        logic        eop;
    } beat_t;

    beat_t got_q[$];
    beat_t exp_q[$];
    int    got_cyc[$];
    int    errors = 0, checks = 0, cyc = 0;
    int    rdy_mode = 0;
    logic  chk_rdy = 1'b0, in_is_pay = 1'b0;
    int    rdy_viol = 0, stall_viol = 0, err_pulses = 0, occ = 0, max_occ = 0;
    logic  prev_stall = 1'b0;
    beat_t prev_beat;
    int          exp_blk_cnt  = 0;
    logic [15:0] exp_blk_id   = 16'h0;
    logic [1:0]  exp_err_code = 2'd0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observation at the falling edge: the handshakes seen here complete at the next rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            occ        = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (!bus.m_valid || bus.m_data !== prev_beat.data ||
                               bus.m_sop !== prev_beat.sop || bus.m_eop !== prev_beat.eop))
                stall_viol++;
            if (chk_rdy && (bus.s_ready !== (occ != 2))) rdy_viol++;
            if (err_pulse) err_pulses++;
            if (bus.m_valid && bus.m_ready) begin
                got_q.push_back('{data: bus.m_data, sop: bus.m_sop, eop: bus.m_eop});
                got_cyc.push_back(cyc);
                occ--;
            end
            if (bus.s_valid && bus.s_ready && in_is_pay) occ++;
            if (occ > max_occ) max_occ = occ;
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_beat  = '{data: bus.m_data, sop: bus.m_sop, eop: bus.m_eop};
        end
    end

    initial begin : m_ready_drv
        bus.m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.m_ready = 1'b1;
                1:       bus.m_ready = !bus.m_ready;
                2:       bus.m_ready = 1'($urandom_range(0, 1));
                default: bus.m_ready = 1'b0;
            endcase
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [63:0] w, input logic pay, output int acc);
        int n;
        bus.s_valid = 1'b1;
        bus.s_data  = w;
        in_is_pay   = pay;
        n   = 0;
        acc = -1;
        forever begin
            @(negedge clk);
            if (bus.s_ready) break;
            n++;
            if (n > 500) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: s_ready got 0 want 1 within %0d cycles", n);
                return;
            end
        end
        @(posedge clk);
        #1;
        acc = cyc;
    endtask

    task automatic idle_in();
        bus.s_valid = 1'b0;
        in_is_pay   = 1'b0;
    endtask

    function automatic logic [63:0] mk_hdr(input logic [7:0] sy, input logic [15:0] id,
                                           input logic [4:0] len);
        logic [34:0] junk;
        junk = {3'($urandom), $urandom};
        return {sy, id, junk, len};
    endfunction

    task automatic send_good(input logic [15:0] id, input int len,
                             output int acc_first, output int acc_last);
        int a;
        logic [63:0] w;
        acc_first = -1;
        acc_last  = -1;
        send_word(mk_hdr(8'hBC, id, 5'(len)), 1'b0, a);
        for (int i = 0; i < len; i++) begin
            w = {$urandom, $urandom};
            exp_q.push_back('{data: w, sop: (i == 0), eop: (i == len - 1)});
            send_word(w, 1'b1, a);
            if (i == 0) acc_first = a;
            acc_last = a;
        end
        exp_blk_cnt++;
        exp_blk_id = id;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (got_q.size() < exp_q.size() && n < budget) begin
            step(1);
            n++;
        end
        step(4);
    endtask

    task automatic clear_q();
        got_q.delete();
        exp_q.delete();
        got_cyc.delete();
    endtask

    function automatic int stream_diff();
        int d;
        d = (got_q.size() > exp_q.size()) ? got_q.size() - exp_q.size()
                                          : exp_q.size() - got_q.size();
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i]) d++;
        return d;
    endfunction

    task automatic test_reset();
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL rst_s_ready: got %0b want 0", bus.s_ready); end
        checks++; if ({bus.m_valid, bus.m_sop, bus.m_eop} !== 3'b000) begin errors++; $display("FAIL rst_m_ctl: got %03b want 000", {bus.m_valid, bus.m_sop, bus.m_eop}); end
        checks++; if (bus.m_data !== 64'h0) begin errors++; $display("FAIL rst_m_data: got %0h want 0", bus.m_data); end
        checks++; if (blk_id !== 16'h0 || blk_cnt !== 16'h0) begin errors++; $display("FAIL rst_blk: got id %0h cnt %0d want 0 0", blk_id, blk_cnt); end
        checks++; if ({err_pulse, err_code} !== 3'b000) begin errors++; $display("FAIL rst_err: got %0b/%0d want 0/0", err_pulse, err_code); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(1);
        checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %0b want 1", bus.s_ready); end
    endtask

    task automatic test_basic();
        int af, al, fc;
        clear_q();
        rdy_mode = 0;
        step(2);
        send_good(16'h1234, 3, af, al);
        idle_in();
        drain(100);
        checks++; if (stream_diff() !== 0) begin errors++; $display("FAIL basic_stream: got %0d beats (%0d diffs) want %0d", got_q.size(), stream_diff(), exp_q.size()); end
        fc = (got_cyc.size() > 0) ? got_cyc[0] : -1;
        checks++; if (fc !== af) begin errors++; $display("FAIL basic_latency: first beat cycle %0d want %0d", fc, af); end
        checks++; if (blk_id !== 16'h1234) begin errors++; $display("FAIL basic_blk_id: got %0h want 1234", blk_id); end
        checks++; if (blk_cnt !== 16'(exp_blk_cnt)) begin errors++; $display("FAIL basic_blk_cnt: got %0d want %0d", blk_cnt, exp_blk_cnt); end
    endtask

    task automatic test_back_to_back();
        int af, al, a1, a2, span;
        clear_q();
        send_good(16'h0D0D, 1, a1, a2);
        send_good(16'h1717, 17, af, al);
        idle_in();
        drain(200);
        checks++; if (stream_diff() !== 0) begin errors++; $display("FAIL b2b_stream: got %0d beats (%0d diffs) want %0d", got_q.size(), stream_diff(), exp_q.size()); end
        checks++; if (al - af !== 16) begin errors++; $display("FAIL b2b_input_rate: span %0d want 16", al - af); end
        span = (got_cyc.size() >= 18) ? got_cyc[17] - got_cyc[1] : -1;
        checks++; if (span !== 16) begin errors++; $display("FAIL b2b_output_rate: span %0d want 16", span); end
        checks++; if (blk_cnt !== 16'(exp_blk_cnt) || blk_id !== 16'h1717) begin errors++; $display("FAIL b2b_status: got cnt %0d id %0h want %0d 1717", blk_cnt, blk_id, exp_blk_cnt); end
    endtask

    task automatic test_stall();
        int af, al;
        clear_q();
        rdy_viol = 0; stall_viol = 0; max_occ = 0;
        chk_rdy  = 1'b1;
        rdy_mode = 1;
        send_good(16'h4444, 4, af, al);
        idle_in();
        drain(200);
        chk_rdy  = 1'b0;
        rdy_mode = 0;
        step(2);
        checks++; if (stream_diff() !== 0) begin errors++; $display("FAIL stall_stream: got %0d beats (%0d diffs) want %0d", got_q.size(), stream_diff(), exp_q.size()); end
        checks++; if (stall_viol !== 0) begin errors++; $display("FAIL stall_hold: got %0d unstable cycles want 0", stall_viol); end
        checks++; if (rdy_viol !== 0) begin errors++; $display("FAIL stall_s_ready: got %0d wrong cycles want 0", rdy_viol); end
        checks++; if (max_occ !== 2) begin errors++; $display("FAIL stall_fill: max occupancy %0d want 2", max_occ); end
    endtask

    task automatic test_bad_sync();
        int a, af, al, e0;
        clear_q();
        e0 = err_pulses;
        send_word(64'hAA00_0000_0000_0003, 1'b0, a);
        idle_in();
        step(3);
        checks++; if (err_pulses - e0 !== 1) begin errors++; $display("FAIL sync_pulse: got %0d pulses want 1", err_pulses - e0); end
        checks++; if (err_code !== 2'd1) begin errors++; $display("FAIL sync_code: got %0d want 1", err_code); end
        checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL sync_no_beat: got %0d beats want 0", got_q.size()); end
        send_good(16'hBEEF, 2, af, al);
        idle_in();
        drain(100);
        checks++; if (stream_diff() !== 0 || blk_id !== 16'hBEEF) begin errors++; $display("FAIL sync_resync: got %0d diffs id %0h want 0 beef", stream_diff(), blk_id); end
    endtask

    task automatic test_bad_len();
        int a, e0;
        clear_q();
        e0 = err_pulses;
        send_word(mk_hdr(8'hBC, 16'h0101, 5'd0), 1'b0, a);
        idle_in();
        step(3);
        checks++; if (err_pulses - e0 !== 1 || err_code !== 2'd2) begin errors++; $display("FAIL len0: got pulses %0d code %0d want 1 2", err_pulses - e0, err_code); end
        e0 = err_pulses;
        send_word(mk_hdr(8'hBC, 16'h0202, 5'd18), 1'b0, a);
        idle_in();
        step(3);
        checks++; if (err_pulses - e0 !== 1 || err_code !== 2'd2) begin errors++; $display("FAIL len18: got pulses %0d code %0d want 1 2", err_pulses - e0, err_code); end
        send_word(mk_hdr(8'h00, 16'h0303, 5'd0), 1'b0, a);
        idle_in();
        step(3);
        checks++; if (err_code !== 2'd1) begin errors++; $display("FAIL both_bad_code: got %0d want 1", err_code); end
        checks++; if (got_q.size() !== 0 || blk_id !== exp_blk_id) begin errors++; $display("FAIL bad_len_drop: got %0d beats id %0h want 0 %0h", got_q.size(), blk_id, exp_blk_id); end
    endtask

    task automatic test_reset_mid();
        int a, af, al;
        clear_q();
        rdy_mode = 3;
        step(2);
        send_word(mk_hdr(8'hBC, 16'h5555, 5'd5), 1'b0, a);
        send_word({$urandom, $urandom}, 1'b1, a);
        send_word({$urandom, $urandom}, 1'b1, a);
        idle_in();
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(1);
        exp_blk_cnt = 0;
        exp_blk_id  = 16'h0;
        checks++; if (bus.m_valid !== 1'b0 || blk_cnt !== 16'h0) begin errors++; $display("FAIL midrst_state: got m_valid %0b cnt %0d want 0 0", bus.m_valid, blk_cnt); end
        checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %0b want 1", bus.s_ready); end
        clear_q();
        rdy_mode = 0;
        send_good(16'h7777, 2, af, al);
        idle_in();
        drain(100);
        checks++; if (stream_diff() !== 0) begin errors++; $display("FAIL midrst_stream: got %0d beats (%0d diffs) want %0d", got_q.size(), stream_diff(), exp_q.size()); end
        checks++; if (blk_id !== 16'h7777 || blk_cnt !== 16'd1) begin errors++; $display("FAIL midrst_status: got id %0h cnt %0d want 7777 1", blk_id, blk_cnt); end
    endtask

    task automatic test_random();
        int a, af, al, e0, nbad;
        logic [7:0] sy;
        logic [4:0] ln;
        clear_q();
        rdy_viol = 0; stall_viol = 0;
        e0   = err_pulses;
        nbad = 0;
        chk_rdy  = 1'b1;
        rdy_mode = 2;
        for (int i = 0; i < 30; i++) begin
            if (i == 0 || $urandom_range(0, 4) == 0) begin
                if ($urandom_range(0, 1) == 1) begin
                    sy = 8'($urandom_range(0, 255));
                    if (sy == 8'hBC) sy = 8'h3C;
                    ln = 5'($urandom_range(0, 31));
                end else begin
                    sy = 8'hBC;
                    ln = ($urandom_range(0, 1) == 1) ? 5'd0 : 5'($urandom_range(18, 31));
                end
                send_word(mk_hdr(sy, 16'($urandom), ln), 1'b0, a);
                exp_err_code = (sy != 8'hBC) ? ERR_SYNC : ERR_LEN;
                nbad++;
            end else begin
                send_good(16'($urandom), $urandom_range(1, 17), af, al);
            end
        end
        idle_in();
        drain(3000);
        chk_rdy  = 1'b0;
        rdy_mode = 0;
        checks++; if (stream_diff() !== 0) begin errors++; $display("FAIL rand_stream: got %0d beats (%0d diffs) want %0d", got_q.size(), stream_diff(), exp_q.size()); end
        checks++; if (err_pulses - e0 !== nbad || err_code !== exp_err_code) begin errors++; $display("FAIL rand_err: got %0d pulses code %0d want %0d %0d", err_pulses - e0, err_code, nbad, exp_err_code); end
        checks++; if (blk_cnt !== 16'(exp_blk_cnt) || blk_id !== exp_blk_id) begin errors++; $display("FAIL rand_status: got cnt %0d id %0h want %0d %0h", blk_cnt, blk_id, exp_blk_cnt, exp_blk_id); end
        checks++; if (rdy_viol !== 0 || stall_viol !== 0) begin errors++; $display("FAIL rand_flow: got ready errs %0d hold errs %0d want 0 0", rdy_viol, stall_viol); end
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_stall();
        test_bad_sync();
        test_bad_len();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
